// File: rtl/opsel_pkg.sv
// Shared definitions for the ALU operand-B select stage.
// Holds the skid-buffer FSM encodings and the select-width helper.
// Used by the interface, the extender and the top level.
package opsel_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Select must encode every register source plus the immediate.
    function automatic int sel_width(input int num_reg);
        return $clog2(num_reg + 1);
    endfunction

endpackage

// File: rtl/operand_select_stage_if.sv
// Request/response bundle of the operand select stage.
// master = upstream decode/regfile plus ALU side, slave = the stage itself.
// Optional imm_upper member exists only when OPSEL_UPPER_IMM_EN is defined.
interface operand_select_stage_if
    import opsel_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int NUM_REG = 2
);
    localparam int SEL_W = sel_width(NUM_REG);

    logic                      in_valid;
    logic                      in_ready;
    logic [SEL_W-1:0]          sel;
    logic [NUM_REG*DATA_W-1:0] reg_data;
    logic [IMM_W-1:0]          imm;
    logic                      imm_signed;
`ifdef OPSEL_UPPER_IMM_EN
    logic                      imm_upper;
`endif
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         operand;
    logic                      sel_err;

    modport master (
`ifdef OPSEL_UPPER_IMM_EN
        output imm_upper,
`endif
        output in_valid, sel, reg_data, imm, imm_signed, out_ready,
        input  in_ready, out_valid, operand, sel_err
    );

    modport slave (
`ifdef OPSEL_UPPER_IMM_EN
        input  imm_upper,
`endif
        input  in_valid, sel, reg_data, imm, imm_signed, out_ready,
        output in_ready, out_valid, operand, sel_err
    );

endinterface

// File: rtl/opsel_extend.sv
// Purpose: widen the immediate field to DATA_W (sign/zero, or LUI-style with OPSEL_UPPER_IMM_EN).
// Latency: purely combinational.
// Backpressure: none, no handshake.
module opsel_extend #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic [IMM_W-1:0]  imm,
    input  logic              imm_signed,
`ifdef OPSEL_UPPER_IMM_EN
    input  logic              imm_upper,
`endif
    output logic [DATA_W-1:0] ext
);
    logic [DATA_W-1:0] low_ext;
    logic [DATA_W-1:0] high_ext;

    generate
        if (DATA_W == IMM_W) begin : g_pass
            // No room to extend into: the field already fills the operand.
            assign low_ext  = imm;
            assign high_ext = imm;
        end else begin : g_ext
            assign low_ext  = {{(DATA_W-IMM_W){imm_signed & imm[IMM_W-1]}}, imm};
            assign high_ext = {imm, {(DATA_W-IMM_W){1'b0}}};
        end
    endgenerate

`ifdef OPSEL_UPPER_IMM_EN
    // Upper placement overrides the sign/zero choice entirely.
    assign ext = imm_upper ? high_ext : low_ext;
`else
    assign ext = low_ext;
    logic unused_high;
    assign unused_high = ^high_ext;
`endif

endmodule

// File: rtl/operand_select_stage.sv
// Purpose: pick register slice or extended immediate as ALU operand B, buffered in a 2-entry skid.
// Latency: 1 cycle from capture edge to out_valid; 1 operand/cycle with out_ready high.
// Backpressure: in_ready (registered) drops only when both entries are full.
module operand_select_stage
    import opsel_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int NUM_REG = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    operand_select_stage_if.slave bus
);
    localparam int SEL_W = sel_width(NUM_REG);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } entry_t;

    state_t            state;
    state_t            state_nxt;
    entry_t            cand;
    entry_t            main_q;
    entry_t            skid_q;
    logic [DATA_W-1:0] imm_ext;
    logic              push;
    logic              pop;

    opsel_extend #(.DATA_W(DATA_W), .IMM_W(IMM_W)) u_extend (
        .imm        (bus.imm),
        .imm_signed (bus.imm_signed),
`ifdef OPSEL_UPPER_IMM_EN
        .imm_upper  (bus.imm_upper),
`endif
        .ext        (imm_ext)
    );

    assign push = bus.in_valid  & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    // Source mux: out-of-range select yields a zero operand flagged as an error.
    always_comb begin
        cand.data = '0;
        cand.err  = 1'b1;
        for (int k = 0; k < NUM_REG; k++) begin
            if (bus.sel == SEL_W'(k)) begin
                cand.data = bus.reg_data[k*DATA_W +: DATA_W];
                cand.err  = 1'b0;
            end
        end
        if (bus.sel == SEL_W'(NUM_REG)) begin
            cand.data = imm_ext;
            cand.err  = 1'b0;
        end
    end

    // FSM state register; reset drops any buffered entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    // Next-state: occupancy moves by +1 on push-only, -1 on pop-only.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (push) state_nxt = ST_ONE;
            ST_ONE: begin
                if (push && !pop)      state_nxt = ST_TWO;
                else if (pop && !push) state_nxt = ST_EMPTY;
            end
            ST_TWO:   if (pop) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // Handshake outputs decode the state flop only, so no input reaches them combinationally.
    always_comb begin
        bus.out_valid = (state == ST_ONE) || (state == ST_TWO);
        bus.in_ready  = (state == ST_EMPTY) || (state == ST_ONE);
    end

    // Data path: main register feeds the ALU, skid catches the entry that arrives under a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            case (state)
                ST_EMPTY: if (push) main_q <= cand;
                ST_ONE: begin
                    if (push && pop) main_q <= cand;
                    else if (push)   skid_q <= cand;
                end
                ST_TWO:   if (pop) main_q <= skid_q;
                default: ;
            endcase
        end
    end

    assign bus.operand = main_q.data;
    assign bus.sel_err = main_q.err;

endmodule

// File: tb/tb_operand_select_stage.sv
// Bench for operand_select_stage (DATA_W=32, IMM_W=16, NUM_REG=2).
// A queue model predicts every output cycle; directed vectors add literal expectations.
// Honours OPSEL_UPPER_IMM_EN the same way as the design.
module tb_operand_select_stage;
    localparam int DATA_W  = 32;
    localparam int IMM_W   = 16;
    localparam int NUM_REG = 2;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;
    int   pops;

    operand_select_stage_if #(.DATA_W(DATA_W), .IMM_W(IMM_W), .NUM_REG(NUM_REG)) bus ();

    operand_select_stage #(.DATA_W(DATA_W), .IMM_W(IMM_W), .NUM_REG(NUM_REG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected {err, operand} from the select rules, using plain arithmetic.
    function automatic logic [32:0] model(input int s, input logic [63:0] rd,
                                          input logic [15:0] im, input bit sg, input bit up);
        logic [63:0] v;
        if (s < NUM_REG) begin
            v = (rd >> (32 * s)) & 64'hFFFF_FFFF;
            return {1'b0, v[31:0]};
        end else if (s == NUM_REG) begin
            if (up)                       v = 64'(im) * 64'd65536;
            else if (sg && im >= 16'h8000) v = 64'(im) + 64'hFFFF_0000;
            else                          v = 64'(im);
            return {1'b0, v[31:0]};
        end
        return {1'b1, 32'h0};
    endfunction

    logic [32:0] q[$];

    // Compare process: check outputs against the model, then advance the model for the next edge.
    always @(negedge clk) begin
        bit exp_v;
        bit exp_r;
        bit up_now;
        if (!rst_n) begin
            q.delete();
            chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
            chk("rst_operand",   64'(bus.operand),   64'd0);
            chk("rst_sel_err",   64'(bus.sel_err),   64'd0);
        end else begin
            exp_v = (q.size() > 0);
            exp_r = (q.size() < 2);
            chk("out_valid", 64'(bus.out_valid), 64'(exp_v));
            chk("in_ready",  64'(bus.in_ready),  64'(exp_r));
            if (exp_v) begin
                chk("operand", 64'(bus.operand), 64'(q[0][31:0]));
                chk("sel_err", 64'(bus.sel_err), 64'(q[0][32]));
            end
`ifdef OPSEL_UPPER_IMM_EN
            up_now = bus.imm_upper;
`else
            up_now = 1'b0;
`endif
            if (exp_v && bus.out_ready) begin
                void'(q.pop_front());
                pops++;
            end
            if (bus.in_valid && exp_r)
                q.push_back(model(int'(bus.sel), bus.reg_data, bus.imm, bus.imm_signed, up_now));
        end
    end

    task automatic issue(input logic [1:0] s, input logic [63:0] rd, input logic [15:0] im,
                         input logic sg, input logic up);
        logic r;
        int   t;
        @(posedge clk);
        #1;
        bus.sel        = s;
        bus.reg_data   = rd;
        bus.imm        = im;
        bus.imm_signed = sg;
`ifdef OPSEL_UPPER_IMM_EN
        bus.imm_upper  = up;
`else
        if (up) bus.imm_signed = sg;
`endif
        bus.in_valid   = 1'b1;
        r = 1'b0;
        t = 0;
        while (!r && t < 20) begin
            @(negedge clk);
            r = bus.in_ready;
            @(posedge clk);
            t++;
        end
        #1 bus.in_valid = 1'b0;
`ifdef OPSEL_UPPER_IMM_EN
        bus.imm_upper = 1'b0;
`endif
        if (!r) chk("issue_timeout", 64'd0, 64'd1);
    endtask

    // Issue with out_ready high and an empty stage; the operand must show the very next cycle.
    task automatic issue_chk(input string nm, input logic [1:0] s, input logic [63:0] rd,
                             input logic [15:0] im, input logic sg, input logic up,
                             input logic [31:0] exp_op, input logic exp_err);
        issue(s, rd, im, sg, up);
        @(negedge clk);
        chk({nm, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({nm, "_op"},    64'(bus.operand),   64'(exp_op));
        chk({nm, "_err"},   64'(bus.sel_err),   64'(exp_err));
    endtask

    initial begin
        logic r;
        int   t;
        int   pops0;
        n_vec = 0;
        n_bad = 0;
        pops  = 0;
        rst_n = 1'b0;
        bus.in_valid   = 1'b0;
        bus.sel        = '0;
        bus.reg_data   = '0;
        bus.imm        = '0;
        bus.imm_signed = 1'b0;
`ifdef OPSEL_UPPER_IMM_EN
        bus.imm_upper  = 1'b0;
`endif
        bus.out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Register slices.
        issue_chk("sel0", 2'd0, {32'h0, 32'hFFFF_FFFF}, 16'h0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        issue_chk("sel1", 2'd1, {32'h1234_5678, 32'h0}, 16'h0, 1'b0, 1'b0, 32'h1234_5678, 1'b0);

        // Immediate extension.
        issue_chk("imm_sx", 2'd2, 64'h0, 16'hFFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0);
        issue_chk("imm_zx", 2'd2, 64'h0, 16'hFFFF, 1'b0, 1'b0, 32'h0000_FFFF, 1'b0);
        issue_chk("imm_pos", 2'd2, 64'h0, 16'h7FFF, 1'b1, 1'b0, 32'h0000_7FFF, 1'b0);

        // Bad select then recovery.
        issue_chk("sel3", 2'd3, {32'h1111_1111, 32'h2222_2222}, 16'h1234, 1'b1, 1'b0, 32'h0, 1'b1);
        issue_chk("sel0b", 2'd0, {32'h0, 32'hA5A5_A5A5}, 16'h0, 1'b0, 1'b0, 32'hA5A5_A5A5, 1'b0);

        // Upper-immediate placement, or plain sign extension without the feature.
`ifdef OPSEL_UPPER_IMM_EN
        issue_chk("imm_up", 2'd2, 64'h0, 16'hABCD, 1'b1, 1'b1, 32'hABCD_0000, 1'b0);
`else
        issue_chk("imm_up", 2'd2, 64'h0, 16'hABCD, 1'b1, 1'b1, 32'hFFFF_ABCD, 1'b0);
`endif

        // Backpressure: A and B fill the stage, C must wait.
        repeat (2) @(posedge clk);
        pops0 = pops;
        #1 bus.out_ready = 1'b0;
        issue(2'd0, {32'h0, 32'hAAAA_0001}, 16'h0, 1'b0, 1'b0);
        issue(2'd1, {32'hBBBB_0002, 32'h0}, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_head",     64'(bus.operand),  64'h0000_0000_AAAA_0001);
        @(posedge clk);
        #1;
        bus.sel        = 2'd2;
        bus.imm        = 16'hC003;
        bus.imm_signed = 1'b0;
        bus.in_valid   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp_hold_op", 64'(bus.operand), 64'h0000_0000_AAAA_0001);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        r = 1'b0;
        t = 0;
        while (!r && t < 20) begin
            @(negedge clk);
            r = bus.in_ready;
            @(posedge clk);
            t++;
        end
        #1 bus.in_valid = 1'b0;
        if (!r) chk("bp_c_timeout", 64'd0, 64'd1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("bp_drained", 64'(pops - pops0), 64'd3);

        // Reset with both entries full.
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        issue(2'd0, {32'h0, 32'h0101_0101}, 16'h0, 1'b0, 1'b0);
        issue(2'd0, {32'h0, 32'h0202_0202}, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("arst_operand",   64'(bus.operand),   64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        issue_chk("post_rst", 2'd1, {32'hCAFE_F00D, 32'h0}, 16'h0, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d miscompares %0d", n_vec, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
